// File: rtl/inst_fetch_decode.sv
// Instruction fetch/decode front end: registers fetch validity and pc of the
// word being returned by the synchronous instruction memory, decodes that word
// into a microcode control word and loads the s0 stage for the control unit.
module inst_fetch_decode #(
    parameter logic [29:0] RESET_PC = 30'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_enable,
    input  logic [29:0] pc,
    output logic [29:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_busy,
    input  logic        block_inst,
    output logic [31:0] microcode_s0,
    output logic [24:0] instruction_data_s0,
    output logic        illegal_inst,
    output logic [29:0] illegal_pc
);

    // Major opcodes (inst[6:0]); all legal ones end in 2'b11.
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // Microcode single-bit positions.
    localparam int B_CHECK_RS1   = 0;
    localparam int B_CHECK_RS2   = 1;
    localparam int B_A_TO_ALU    = 6;
    localparam int B_B_TO_ALU    = 7;
    localparam int B_MEM_WE      = 15;
    localparam int B_ALU_TO_ADDR = 16;
    localparam int B_JUMP        = 17;
    localparam int B_MEM_IN_USE  = 18;
    localparam int B_REG_WE      = 19;
    localparam int B_UP_TO_REG   = 20;
    localparam int B_ALU_TO_REG  = 21;
    localparam int B_RET_TO_REG  = 22;
    localparam int B_MEM_TO_REG  = 23;

    // Operand select and ALU / branch encodings.
    localparam logic [1:0] A_PC    = 2'b01;
    localparam logic [1:0] B_IMM_I = 2'b01;
    localparam logic [1:0] B_IMM_S = 2'b10;
    localparam logic [1:0] B_IMM_U = 2'b11;
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [2:0] COND_TRUE = 3'd7;

    logic        fetch_valid;
    logic [29:0] pc_si;
    logic [31:0] dec_word;
    logic        dec_illegal;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       alt;

    assign imem_addr = pc;
    assign opcode    = imem_rdata[6:0];
    assign funct3    = imem_rdata[14:12];
    assign alt       = imem_rdata[30];

    // ALU operation from funct3; inst[30] picks sra on 101, and sub on 000
    // only for register-register ops (for OP-IMM it is an immediate bit).
    function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3,
                                                   input logic alt_bit,
                                                   input logic allow_sub);
        logic [3:0] op;
        case (f3)
            3'b000:  op = (allow_sub && alt_bit) ? 4'd1 : 4'd0;
            3'b001:  op = 4'd2;
            3'b010:  op = 4'd3;
            3'b011:  op = 4'd4;
            3'b100:  op = 4'd5;
            3'b101:  op = alt_bit ? 4'd7 : 4'd6;
            3'b110:  op = 4'd8;
            default: op = 4'd9;
        endcase
        return op;
    endfunction

    // Combinational decode of the word returned by instruction memory.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        dec_word    = '0;
        dec_illegal = 1'b0;
        case (opcode)
            OPC_LUI: begin
                dec_word[B_REG_WE]    = 1'b1;
                dec_word[B_UP_TO_REG] = 1'b1;
            end
            OPC_AUIPC: begin
                dec_word[3:2]          = A_PC;
                dec_word[5:4]          = B_IMM_U;
                dec_word[B_A_TO_ALU]   = 1'b1;
                dec_word[B_B_TO_ALU]   = 1'b1;
                dec_word[11:8]         = ALU_ADD;
                dec_word[B_REG_WE]     = 1'b1;
                dec_word[B_ALU_TO_REG] = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                dec_word[B_CHECK_RS1]  = (opcode == OPC_JALR);
                dec_word[14:12]        = COND_TRUE;
                dec_word[B_JUMP]       = 1'b1;
                dec_word[B_REG_WE]     = 1'b1;
                dec_word[B_RET_TO_REG] = 1'b1;
            end
            OPC_BRANCH: begin
                dec_word[B_CHECK_RS1] = 1'b1;
                dec_word[B_CHECK_RS2] = 1'b1;
                dec_word[B_JUMP]      = 1'b1;
                case (funct3)
                    3'b000:  dec_word[14:12] = 3'd1;
                    3'b001:  dec_word[14:12] = 3'd2;
                    3'b100:  dec_word[14:12] = 3'd3;
                    3'b101:  dec_word[14:12] = 3'd4;
                    3'b110:  dec_word[14:12] = 3'd5;
                    3'b111:  dec_word[14:12] = 3'd6;
                    default: dec_illegal     = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                dec_illegal             = (funct3 != 3'b010);
                dec_word[B_CHECK_RS1]   = 1'b1;
                dec_word[5:4]           = B_IMM_I;
                dec_word[B_A_TO_ALU]    = 1'b1;
                dec_word[B_B_TO_ALU]    = 1'b1;
                dec_word[11:8]          = ALU_ADD;
                dec_word[B_ALU_TO_ADDR] = 1'b1;
                dec_word[B_MEM_IN_USE]  = 1'b1;
                dec_word[B_REG_WE]      = 1'b1;
                dec_word[B_MEM_TO_REG]  = 1'b1;
            end
            OPC_STORE: begin
                dec_illegal             = (funct3 != 3'b010);
                dec_word[B_CHECK_RS1]   = 1'b1;
                dec_word[B_CHECK_RS2]   = 1'b1;
                dec_word[5:4]           = B_IMM_S;
                dec_word[B_A_TO_ALU]    = 1'b1;
                dec_word[B_B_TO_ALU]    = 1'b1;
                dec_word[11:8]          = ALU_ADD;
                dec_word[B_MEM_WE]      = 1'b1;
                dec_word[B_ALU_TO_ADDR] = 1'b1;
                dec_word[B_MEM_IN_USE]  = 1'b1;
            end
            OPC_OP_IMM: begin
                dec_word[B_CHECK_RS1]  = 1'b1;
                dec_word[5:4]          = B_IMM_I;
                dec_word[B_A_TO_ALU]   = 1'b1;
                dec_word[B_B_TO_ALU]   = 1'b1;
                dec_word[11:8]         = alu_from_funct3(funct3, alt, 1'b0);
                dec_word[B_REG_WE]     = 1'b1;
                dec_word[B_ALU_TO_REG] = 1'b1;
            end
            OPC_OP: begin
                dec_word[B_CHECK_RS1]  = 1'b1;
                dec_word[B_CHECK_RS2]  = 1'b1;
                dec_word[B_A_TO_ALU]   = 1'b1;
                dec_word[B_B_TO_ALU]   = 1'b1;
                dec_word[11:8]         = alu_from_funct3(funct3, alt, 1'b1);
                dec_word[B_REG_WE]     = 1'b1;
                dec_word[B_ALU_TO_REG] = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // Fetch tracking, s0 load with bubble insertion, and sticky illegal capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_valid         <= 1'b0;
            pc_si               <= '0;
            microcode_s0        <= '0;
            instruction_data_s0 <= '0;
            illegal_inst        <= 1'b0;
            illegal_pc          <= RESET_PC;
        end else if (clk_enable) begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values (s0 sees the old fetch_valid, not the new one).
            fetch_valid <= ~imem_busy;
            pc_si       <= pc;
            if (block_inst || !fetch_valid || dec_illegal) begin
                microcode_s0        <= '0;
                instruction_data_s0 <= '0;
            end else begin
                microcode_s0        <= dec_word;
                instruction_data_s0 <= imem_rdata[31:7];
            end
            // A blocked illegal word will be refetched, so it is not flagged yet.
            if (fetch_valid && !block_inst && dec_illegal && !illegal_inst) begin
                illegal_inst <= 1'b1;
                illegal_pc   <= pc_si;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_decode.sv
// Directed bench for inst_fetch_decode: a decode vector table plus short
// hand-written sequences for reset, busy, block, illegal, enable and async reset.
module tb_inst_fetch_decode;

    localparam logic [29:0] RST_PC = 30'h0ABC;

    logic        clk;
    logic        rst_n;
    logic        clk_enable;
    logic [29:0] pc;
    logic [29:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_busy;
    logic        block_inst;
    logic [31:0] microcode_s0;
    logic [24:0] instruction_data_s0;
    logic        illegal_inst;
    logic [29:0] illegal_pc;

    int tests  = 0;
    int failed = 0;

    inst_fetch_decode #(.RESET_PC(RST_PC)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .clk_enable          (clk_enable),
        .pc                  (pc),
        .imem_addr           (imem_addr),
        .imem_rdata          (imem_rdata),
        .imem_busy           (imem_busy),
        .block_inst          (block_inst),
        .microcode_s0        (microcode_s0),
        .instruction_data_s0 (instruction_data_s0),
        .illegal_inst        (illegal_inst),
        .illegal_pc          (illegal_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic [31:0] mc;
        logic [24:0] data;
    } vec_t;

    vec_t vecs [20];
    logic [31:0] bad_words [3];

    localparam logic [31:0] W_ADDI = 32'h00500093;
    localparam logic [31:0] W_BEQ  = 32'h00208463;
    localparam logic [31:0] W_LW   = 32'h0040A103;
    localparam logic [31:0] W_SW   = 32'h0020A423;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_s0(input string name, input logic [31:0] mc, input logic [24:0] data);
        check({name, ".mc"}, microcode_s0, mc);
        check({name, ".data"}, {7'd0, instruction_data_s0}, {7'd0, data});
    endtask

    initial begin
        vecs[0]  = '{"addi",  W_ADDI,       32'h002800D1, 25'h000A001};
        vecs[1]  = '{"beq",   W_BEQ,        32'h00021003, 25'h0004108};
        vecs[2]  = '{"lui",   32'h123452B7, 32'h00180000, 25'h02468A5};
        vecs[3]  = '{"auipc", 32'h00000097, 32'h002800F4, 25'h0000001};
        vecs[4]  = '{"jal",   32'h000000EF, 32'h004A7000, 25'h0000001};
        vecs[5]  = '{"jalr",  32'h00008067, 32'h004A7001, 25'h0000100};
        vecs[6]  = '{"bne",   32'h00209463, 32'h00022003, 25'h0004128};
        vecs[7]  = '{"bgeu",  32'h0020F463, 32'h00026003, 25'h00041E8};
        vecs[8]  = '{"blt",   32'h0020C463, 32'h00023003, 25'h0004188};
        vecs[9]  = '{"lw",    W_LW,         32'h008D00D1, 25'h0008142};
        vecs[10] = '{"sw",    W_SW,         32'h000580E3, 25'h0004148};
        vecs[11] = '{"srai",  32'h4030D093, 32'h002807D1, 25'h08061A1};
        vecs[12] = '{"addi30",32'h40000093, 32'h002800D1, 25'h0800001};
        vecs[13] = '{"sub",   32'h403100B3, 32'h002801C3, 25'h0806201};
        vecs[14] = '{"add",   32'h003100B3, 32'h002800C3, 25'h0006201};
        vecs[15] = '{"and",   32'h003170B3, 32'h002809C3, 25'h00062E1};
        vecs[16] = '{"sra",   32'h403150B3, 32'h002807C3, 25'h08062A1};
        vecs[17] = '{"sltiu", 32'h00503093, 32'h002804D1, 25'h000A061};
        vecs[18] = '{"xori",  32'h00504093, 32'h002805D1, 25'h000A081};
        vecs[19] = '{"slli",  32'h00501093, 32'h002802D1, 25'h000A021};

        bad_words[0] = 32'h0020A463;  // branch funct3 010
        bad_words[1] = 32'h00008103;  // load funct3 000
        bad_words[2] = 32'h00500090;  // inst[1:0] = 00

        rst_n = 1'b0; clk_enable = 1'b1; pc = 30'h5;
        imem_rdata = 32'h0; imem_busy = 1'b0; block_inst = 1'b0;
        step(); step();

        // Reset state and combinational address path.
        check_s0("reset", 32'h0, 25'h0);
        check("reset.illegal_inst", {31'd0, illegal_inst}, 32'd0);
        check("reset.illegal_pc", {2'd0, illegal_pc}, {2'd0, RST_PC});
        check("imem_addr", {2'd0, imem_addr}, 32'h5);

        // Release: first s0 load is a bubble, the second decodes ADDI.
        rst_n = 1'b1; pc = 30'h0; imem_rdata = W_ADDI;
        step();
        check_s0("first_bubble", 32'h0, 25'h0);
        step();
        check_s0("first_addi", 32'h002800D1, 25'h000A001);

        // Decode table with continuous valid fetches.
        for (int i = 0; i < 20; i++) begin
            pc = 30'(i + 1);
            imem_rdata = vecs[i].rdata;
            step();
            check_s0(vecs[i].name, vecs[i].mc, vecs[i].data);
        end
        check("table.no_illegal", {31'd0, illegal_inst}, 32'd0);

        // imem_busy affects only the following s0 load.
        imem_busy = 1'b1; imem_rdata = W_BEQ;
        step();
        check_s0("busy_same_cycle", 32'h00021003, 25'h0004108);
        imem_busy = 1'b0; imem_rdata = W_ADDI;
        step();
        check_s0("busy_bubble", 32'h0, 25'h0);
        imem_rdata = W_BEQ;
        step();
        check_s0("after_busy", 32'h00021003, 25'h0004108);

        // Two blocked loads, then resume on the first unblocked edge.
        block_inst = 1'b1; imem_rdata = W_ADDI;
        step();
        check_s0("block1", 32'h0, 25'h0);
        step();
        check_s0("block2", 32'h0, 25'h0);
        block_inst = 1'b0;
        step();
        check_s0("unblock", 32'h002800D1, 25'h000A001);

        // Blocked illegal word: bubble and no flag.
        block_inst = 1'b1; imem_rdata = 32'hFFFFFFFF;
        step();
        check_s0("block_illegal", 32'h0, 25'h0);
        check("block_illegal.flag", {31'd0, illegal_inst}, 32'd0);
        block_inst = 1'b0; imem_rdata = W_ADDI;

        // FENCE at pc 0x10 then 0xFFFFFFFF at 0x11: capture stays at 0x10.
        pc = 30'h10;
        step();
        pc = 30'h11; imem_rdata = 32'h0000000F;
        step();
        check_s0("fence", 32'h0, 25'h0);
        check("fence.flag", {31'd0, illegal_inst}, 32'd1);
        check("fence.pc", {2'd0, illegal_pc}, 32'h10);
        pc = 30'h12; imem_rdata = 32'hFFFFFFFF;
        step();
        check_s0("ones", 32'h0, 25'h0);
        check("ones.pc", {2'd0, illegal_pc}, 32'h10);
        for (int i = 0; i < 3; i++) begin
            imem_rdata = bad_words[i];
            step();
            check_s0($sformatf("bad%0d", i), 32'h0, 25'h0);
        end
        check("bad.pc", {2'd0, illegal_pc}, 32'h10);
        check("bad.flag", {31'd0, illegal_inst}, 32'd1);

        // clk_enable low: everything holds, including fetch_valid.
        imem_rdata = W_LW;
        step();
        check_s0("pre_hold", 32'h008D00D1, 25'h0008142);
        clk_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            imem_rdata = vecs[i].rdata;
            imem_busy  = 1'b1;
            block_inst = i[0];
            pc = 30'(i + 40);
            step();
            check_s0($sformatf("hold%0d", i), 32'h008D00D1, 25'h0008142);
        end
        clk_enable = 1'b1; imem_busy = 1'b0; block_inst = 1'b0; imem_rdata = W_SW;
        step();
        check_s0("after_hold", 32'h000580E3, 25'h0004148);

        // Asynchronous reset between edges clears outputs immediately.
        #2;
        rst_n = 1'b0;
        #1;
        check_s0("async_rst", 32'h0, 25'h0);
        check("async_rst.flag", {31'd0, illegal_inst}, 32'd0);
        check("async_rst.pc", {2'd0, illegal_pc}, {2'd0, RST_PC});
        step();
        rst_n = 1'b1; imem_rdata = W_ADDI;
        step();
        check_s0("post_rst_bubble", 32'h0, 25'h0);
        step();
        check_s0("post_rst_addi", 32'h002800D1, 25'h000A001);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
